// File: rtl/regfile_cmd_master.sv
// Register-file command master: buffers read/write commands, issues one strobe at a time, returns one response each.
// Optional saturating completion/timeout counters are enabled by defining REGFILE_CMD_MASTER_STATS_EN.
module regfile_cmd_master #(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rf_write_enable,
    output logic        rf_read_enable,
    output logic [1:0]  rf_address,
    output logic [31:0] rf_write_data,
    input  logic [31:0] rf_read_data,
    input  logic        rf_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
`ifdef REGFILE_CMD_MASTER_STATS_EN
    ,
    output logic [15:0] stat_wr_count,
    output logic [15:0] stat_rd_count,
    output logic [15:0] stat_timeout_count
`endif
);

    localparam int unsigned AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(CMD_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state_q, state_d;

    logic          fifo_write [CMD_DEPTH];
    logic [1:0]    fifo_addr  [CMD_DEPTH];
    logic [31:0]   fifo_wdata [CMD_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_d, re_d, rsp_valid_d, rsp_write_d, rsp_error_d;
    logic [1:0]    addr_d;
    logic [31:0]   wdata_d, rsp_rdata_d;
    logic          done_ok, timed_out;

    // No bypass: a pop in the same cycle does not reopen a full FIFO.
    assign cmd_ready = (count != FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= cmd_write;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = rf_write_enable;
        re_d        = rf_read_enable;
        addr_d      = rf_address;
        wdata_d     = rf_write_data;
        rsp_valid_d = rsp_valid;
        rsp_write_d = rsp_write;
        rsp_rdata_d = rsp_rdata;
        rsp_error_d = rsp_error;
        done_ok     = 1'b0;
        timed_out   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    we_d    = fifo_write[rd_ptr];
                    re_d    = !fifo_write[rd_ptr];
                    addr_d  = fifo_addr[rd_ptr];
                    wdata_d = fifo_write[rd_ptr] ? fifo_wdata[rd_ptr] : '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                // Ready takes priority over a timeout landing on the same edge.
                if (rf_ready) begin
                    done_ok     = 1'b1;
                    we_d        = 1'b0;
                    re_d        = 1'b0;
                    rsp_rdata_d = rf_read_enable ? rf_read_data : '0;
                    rsp_write_d = rf_write_enable;
                    rsp_error_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    timed_out   = 1'b1;
                    we_d        = 1'b0;
                    re_d        = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_write_d = rf_write_enable;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            rf_write_enable <= 1'b0;
            rf_read_enable  <= 1'b0;
            rf_address      <= '0;
            rf_write_data   <= '0;
            rsp_valid       <= 1'b0;
            rsp_write       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_error       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rf_write_enable <= we_d;
            rf_read_enable  <= re_d;
            rf_address      <= addr_d;
            rf_write_data   <= wdata_d;
            rsp_valid       <= rsp_valid_d;
            rsp_write       <= rsp_write_d;
            rsp_rdata       <= rsp_rdata_d;
            rsp_error       <= rsp_error_d;
        end
    end

`ifdef REGFILE_CMD_MASTER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_wr_count      <= '0;
            stat_rd_count      <= '0;
            stat_timeout_count <= '0;
        end else begin
            if (done_ok && rf_write_enable && (stat_wr_count != '1))
                stat_wr_count <= stat_wr_count + 16'd1;
            if (done_ok && rf_read_enable && (stat_rd_count != '1))
                stat_rd_count <= stat_rd_count + 16'd1;
            if (timed_out && (stat_timeout_count != '1))
                stat_timeout_count <= stat_timeout_count + 16'd1;
        end
    end
`endif

endmodule
